// File: rtl/c2f_chunk_drainer.sv
// c2f_chunk_drainer: drains C2F RAM chunks one at a time. Every 64-bit word is
// summed into a running checksum, and each drained chunk is handed back to the
// TLP transceiver with a one-cycle DTAck pulse. A programmable stall after each
// chunk models a slow consumer.
module c2f_chunk_drainer #(
  parameter int INDEX_WIDTH  = 2,
  parameter int OFFSET_WIDTH = 9
) (
  input  logic                    pcieClk_in,
  input  logic                    reset_in,
  input  logic [INDEX_WIDTH-1:0]  wrPtr_in,
  input  logic [INDEX_WIDTH-1:0]  rdPtr_in,
  output logic                    dtAck_out,
  output logic [OFFSET_WIDTH-1:0] rdOffset_out,
  input  logic [63:0]             rdData_in,
  input  logic                    csReset_in,
  input  logic [31:0]             countInit_in,
  output logic [63:0]             csData_out,
  output logic                    csValid_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_STALL, S_ACK, S_WAITPTR
  } state_t;

  state_t                  r_state, w_next;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic [63:0]             r_sum;
  logic [31:0]             r_stall;
  logic [INDEX_WIDTH-1:0]  r_ackPtr;

  logic w_lastOff;
  logic w_add;

  // The read is registered, so the word for offset k arrives while offset
  // k+1 is issued. Offset 0 therefore contributes nothing, and the last word
  // lands during DRAIN.
  assign w_lastOff = &r_offset;
  assign w_add     = ((r_state == S_READ) && (r_offset != '0)) || (r_state == S_DRAIN);

  assign dtAck_out    = (r_state == S_ACK);
  assign rdOffset_out = r_offset;
  assign csData_out   = r_sum;
  assign csValid_out  = (r_state == S_IDLE) && (rdPtr_in == wrPtr_in);

  // State register.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. WAITPTR holds until the transceiver has moved rdPtr
  // past the acked chunk, so a late pointer update cannot cause a second ack.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (rdPtr_in != wrPtr_in) w_next = S_READ;
      S_READ:    if (w_lastOff) w_next = S_DRAIN;
      S_DRAIN:   w_next = (countInit_in == '0) ? S_ACK : S_STALL;
      S_STALL:   if (r_stall <= 32'd1) w_next = S_ACK;
      S_ACK:     w_next = S_WAITPTR;
      S_WAITPTR: if (rdPtr_in != r_ackPtr) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Read offset: steps through the chunk in READ and wraps back to 0 on exit.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in)                r_offset <= '0;
    else if (r_state == S_READ)  r_offset <= r_offset + OFFSET_WIDTH'(1);
    else                         r_offset <= '0;
  end

  // Stall counter: countInit is sampled only in DRAIN.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in)                r_stall <= '0;
    else if (r_state == S_DRAIN) r_stall <= countInit_in;
    else if (r_state == S_STALL) r_stall <= r_stall - 32'd1;
  end

  // Remember which chunk was acked.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in)              r_ackPtr <= '0;
    else if (r_state == S_ACK) r_ackPtr <= rdPtr_in;
  end

  // Checksum: wrapping 64-bit sum. A clear wins over an add in the same cycle.
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in)        r_sum <= '0;
    else if (csReset_in) r_sum <= '0;
    else if (w_add)      r_sum <= r_sum + rdData_in;
  end

endmodule

// File: tb/tb_c2f_chunk_drainer.sv
// tb_c2f_chunk_drainer: directed and randomized chunk traffic against a
// behavioural RAM / checksum / latency model.
module tb_c2f_chunk_drainer;
  localparam int IW = 2;
  localparam int OW = 9;
  localparam int N  = 1 << OW;

  logic          clk = 1'b0;
  logic          reset_in;
  logic [IW-1:0] wrPtr, rdPtr;
  logic          dtAck;
  logic [OW-1:0] rdOffset;
  logic [63:0]   rdData = '0;
  logic          csReset;
  logic [31:0]   countInit;
  logic [63:0]   csData;
  logic          csValid;

  logic [63:0]   mem [0:(4*N)-1];
  logic [63:0]   exp_sum = '0;
  int            cyc = 0;
  int            ack_total = 0;
  int            checks = 0;
  int            errors = 0;

  c2f_chunk_drainer #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
    .pcieClk_in(clk), .reset_in(reset_in), .wrPtr_in(wrPtr), .rdPtr_in(rdPtr),
    .dtAck_out(dtAck), .rdOffset_out(rdOffset), .rdData_in(rdData),
    .csReset_in(csReset), .countInit_in(countInit), .csData_out(csData),
    .csValid_out(csValid)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model and cycle/ack bookkeeping.
  always @(posedge clk) begin
    rdData <= mem[int'({rdPtr, rdOffset})];
    cyc    <= cyc + 1;
    if (dtAck) ack_total <= ack_total + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dtAck === 1'b1) begin at = cyc; break; end
    end
    chk({tag, "_ack_seen"}, 64'(at >= 0), 64'd1);
  endtask

  task automatic wait_offset(input string tag, input logic [OW-1:0] off);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      if (rdOffset == off) begin hit = 1'b1; break; end
    end
    chk({tag, "_offset_reached"}, 64'(hit), 64'd1);
  endtask

  task automatic fill(input int c, input int pat, output logic [63:0] s, output logic [63:0] s200);
    s = '0; s200 = '0;
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       mem[c*N+k] = 64'(k);
        1:       mem[c*N+k] = {$urandom, $urandom};
        default: mem[c*N+k] = '1;
      endcase
      s += mem[c*N+k];
      if (k >= 200) s200 += mem[c*N+k];
    end
  endtask

  task automatic cs_clear();
    @(posedge clk); #1; csReset = 1'b1;
    @(posedge clk); #1; csReset = 1'b0;
    exp_sum = '0;
  endtask

  // One chunk: queue it, expect one ack N+2+cinit cycles later, hold rdPtr
  // for 'hold' cycles, then advance it and check the settled checksum.
  task automatic run_chunk(input string tag, input int cinit, input int hold, input int pat);
    logic [63:0] s, s200;
    int t0, a, acks0;
    fill(int'(wrPtr), pat, s, s200);
    exp_sum += s;
    acks0 = ack_total;
    @(posedge clk); #1;
    countInit = 32'(cinit);
    wrPtr = wrPtr + 2'd1;
    t0 = cyc;
    wait_ack(tag, N + cinit + 50, a);
    chk({tag, "_latency"}, 64'(a - t0), 64'(N + 2 + cinit));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_noack"}, 64'(dtAck), 64'd0);
      chk({tag, "_hold_noread"}, 64'(rdOffset), 64'd0);
    end
    @(posedge clk); #1;
    rdPtr = rdPtr + 2'd1;
    repeat (2) @(negedge clk);
    chk({tag, "_csValid"}, 64'(csValid), 64'd1);
    chk({tag, "_csData"}, csData, exp_sum);
    chk({tag, "_ack_count"}, 64'(ack_total), 64'(acks0 + 1));
  endtask

  initial begin
    logic [63:0] s, s200;
    int a, prev, t0, acks0;

    // Reset state, including combinational csValid while held in reset.
    reset_in = 1'b1; wrPtr = '0; rdPtr = '0; csReset = 1'b0; countInit = '0;
    for (int c = 0; c < 4 * N; c++) mem[c] = '0;
    repeat (3) @(negedge clk);
    chk("rst_dtAck", 64'(dtAck), 64'd0);
    chk("rst_csData", csData, 64'd0);
    chk("rst_csValid_eq", 64'(csValid), 64'd1);
    chk("rst_rdOffset", 64'(rdOffset), 64'd0);
    wrPtr = 2'd1; #1;
    chk("rst_csValid_ne", 64'(csValid), 64'd0);
    wrPtr = 2'd0; #1;
    @(negedge clk); reset_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_csValid", 64'(csValid), 64'd1);
    chk("post_rst_dtAck", 64'(dtAck), 64'd0);
    chk("post_rst_csData", csData, 64'd0);

    // Ramp chunk word[k]=k, no stall.
    run_chunk("ramp0", 0, 0, 0);
    chk("ramp0_const", csData, 64'h1FF00);

    // Same data with a 100-cycle stall: latency grows by exactly 100.
    cs_clear();
    run_chunk("ramp100", 100, 0, 0);
    chk("ramp100_const", csData, 64'h1FF00);

    // rdPtr held 5 cycles after ack: no second ack, no re-read.
    run_chunk("hold5", 0, 5, 1);
    run_chunk("rnd_a", int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 1);

    // Four all-ones chunks queued back to back; wrPtr wraps 3->0.
    for (int c = 0; c < 4; c++) fill(c, 2, s, s200);
    cs_clear();
    for (int c = 0; c < 4; c++) exp_sum += s;
    acks0 = ack_total;
    prev = 0;
    @(posedge clk); #1;
    countInit = '0;
    wrPtr = 2'd3;
    for (int j = 0; j < 4; j++) begin
      wait_ack("queue", N + 50, a);
      if (j > 0) chk("queue_interval", 64'(a - prev), 64'(N + 4));
      prev = a;
      @(posedge clk); #1;
      rdPtr = rdPtr + 2'd1;
      if (j == 0) wrPtr = 2'd0;
    end
    repeat (2) @(negedge clk);
    chk("queue_acks", 64'(ack_total), 64'(acks0 + 4));
    chk("queue_csData", csData, exp_sum);
    chk("queue_const", csData, 64'hFFFF_FFFF_FFFF_F800);
    chk("queue_csValid", 64'(csValid), 64'd1);

    // Checksum clear while offset 200 is on the bus: only words 200..511 survive.
    fill(int'(wrPtr), 1, s, s200);
    acks0 = ack_total;
    @(posedge clk); #1;
    wrPtr = wrPtr + 2'd1;
    wait_offset("csclr", OW'(200));
    csReset = 1'b1;
    @(posedge clk); #1;
    csReset = 1'b0;
    chk("csclr_zero", csData, 64'd0);
    wait_ack("csclr", N + 50, a);
    @(posedge clk); #1;
    rdPtr = rdPtr + 2'd1;
    repeat (2) @(negedge clk);
    exp_sum = s200;
    chk("csclr_csData", csData, exp_sum);
    chk("csclr_acks", 64'(ack_total), 64'(acks0 + 1));

    // Async reset mid-READ: partial sum dropped, chunk re-read, one ack total.
    fill(int'(wrPtr), 1, s, s200);
    acks0 = ack_total;
    @(posedge clk); #1;
    countInit = 32'd3;
    wrPtr = wrPtr + 2'd1;
    wait_offset("arst", OW'(300));
    #2 reset_in = 1'b1;
    #1;
    chk("arst_csData", csData, 64'd0);
    chk("arst_rdOffset", 64'(rdOffset), 64'd0);
    chk("arst_dtAck", 64'(dtAck), 64'd0);
    chk("arst_csValid", 64'(csValid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_in = 1'b0;
    t0 = cyc;
    wait_ack("arst", N + 60, a);
    chk("arst_latency", 64'(a - t0), 64'(N + 2 + 3));
    @(posedge clk); #1;
    rdPtr = rdPtr + 2'd1;
    repeat (2) @(negedge clk);
    exp_sum = s;
    chk("arst_csData_final", csData, exp_sum);
    chk("arst_acks", 64'(ack_total), 64'(acks0 + 1));

    // A few more randomized chunks on top of the running checksum.
    run_chunk("rnd_b", int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 1);
    run_chunk("rnd_c", int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
